// File: rtl/shift_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// shift_tx_ctrl_if
//   Bundles the frame request, the shift-register control/readback lines and
//   the status outputs of shift_tx_ctrl.
//
//   Handshake: start acts as a level request. The controller accepts it on
//   any rising edge of clk_2 where it sits in IDLE (busy=0), including the
//   done cycle. data_in is captured on that same edge. While busy=1, start
//   and data_in are ignored. done pulses for one cycle once the stop bit has
//   been sent.
//
//   Signals (direction seen from the controller / slave modport):
//     start      in   frame request
//     data_in    in   word to send
//     reg_q      in   parallel output of the controlled shift register
//     reg_pdata  out  captured word for the register's parallel input
//     reg_load   out  register parallel-load enable
//     reg_shift  out  register shift-right enable
//     reg_ser_in out  serial fill bit (constant 0)
//     tx         out  serial line, idles high
//     busy       out  frame in progress
//     done       out  one-cycle pulse after the stop bit
//     bit_idx    out  data bits already sent in the current frame
// ---------------------------------------------------------------------------
interface shift_tx_ctrl_if #(
  parameter int NBITS = 4
);
  localparam int IW = $clog2(NBITS + 1);

  logic             start;
  logic [NBITS-1:0] data_in;
  logic [NBITS-1:0] reg_q;
  logic [NBITS-1:0] reg_pdata;
  logic             reg_load;
  logic             reg_shift;
  logic             reg_ser_in;
  logic             tx;
  logic             busy;
  logic             done;
  logic [IW-1:0]    bit_idx;

  // Requester / register-block side.
  modport master (
    output start, data_in, reg_q,
    input  reg_pdata, reg_load, reg_shift, reg_ser_in, tx, busy, done, bit_idx
  );

  // Controller side.
  modport slave (
    input  start, data_in, reg_q,
    output reg_pdata, reg_load, reg_shift, reg_ser_in, tx, busy, done, bit_idx
  );
endinterface

// File: rtl/shift_tx_ctrl.sv
// ---------------------------------------------------------------------------
// shift_tx_ctrl
//   Sequences an external NBITS-wide load/shift register to serialise a
//   parallel word: start bit (0), LSB-first data, optional even parity, stop
//   bit (1). Each serial bit lasts BIT_CYCLES clk_2 cycles.
//
//   Ports:
//     clk_2        in   clock
//     reset        in   synchronous, active-high reset
//     bus          slave modport of shift_tx_ctrl_if (request, register
//                  control/readback, tx, busy/done, bit_idx)
//     o_dbg_state  out  current FSM state code
//
//   All outputs decode registered state, counters and the register readback;
//   start and data_in only influence the next state.
// ---------------------------------------------------------------------------
module shift_tx_ctrl #(
  parameter int NBITS      = 4,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY     = 1
) (
  input  logic           clk_2,
  input  logic           reset,
  shift_tx_ctrl_if.slave bus,
  output logic [2:0]     o_dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_PAR   = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  // Cycle counter needs at least one bit even when BIT_CYCLES is 1.
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(NBITS + 1);

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  logic [2:0]       r_state;
  logic [CW-1:0]    r_cyc_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [NBITS-1:0] r_pdata;
  logic             r_parity;
  logic             r_done;

  logic             w_bit_end;
  logic             w_tx;
  logic             w_load;
  logic             w_shift;
  logic             w_unused_reg_q;

  // Last clk_2 cycle of the current serial bit.
  assign w_bit_end = (r_cyc_cnt == CYC_LAST);

  // Only reg_q[0] feeds the line; the rest of the readback is not needed.
  assign w_unused_reg_q = ^bus.reg_q;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cyc_cnt <= '0;
      r_bit_cnt <= '0;
      r_pdata   <= '0;
      r_parity  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cyc_cnt <= '0;
          r_bit_cnt <= '0;
          if (bus.start) begin
            r_pdata  <= bus.data_in;
            // Even parity: the parity bit makes the total count of ones even.
            r_parity <= ^bus.data_in;
            r_state  <= S_LOAD;
          end
        end

        // Single cycle in which the register takes the captured word.
        S_LOAD: begin
          r_cyc_cnt <= '0;
          r_state   <= S_START;
        end

        S_START: begin
          if (w_bit_end) begin
            r_cyc_cnt <= '0;
            r_state   <= S_DATA;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + CW'(1);
          end
        end

        // The shift pulse and the bit count advance together on the last
        // cycle of each data bit, so reg_q[0] presents the next bit
        // at the start of the following bit period.
        S_DATA: begin
          if (w_bit_end) begin
            r_cyc_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + BW'(1);
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= (PARITY != 0) ? S_PAR : S_STOP;
            end
          end else begin
            r_cyc_cnt <= r_cyc_cnt + CW'(1);
          end
        end

        S_PAR: begin
          if (w_bit_end) begin
            r_cyc_cnt <= '0;
            r_state   <= S_STOP;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + CW'(1);
          end
        end

        // done is registered so it appears in the first IDLE cycle, which is
        // also the cycle in which a back-to-back request can be accepted.
        S_STOP: begin
          if (w_bit_end) begin
            r_cyc_cnt <= '0;
            r_bit_cnt <= '0;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + CW'(1);
          end
        end

        default: begin
          r_cyc_cnt <= '0;
          r_bit_cnt <= '0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Moore decode of line level and register controls.
  always_comb begin
    w_tx    = 1'b1;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      S_LOAD:  w_load = 1'b1;
      S_START: w_tx   = 1'b0;
      S_DATA: begin
        w_tx    = bus.reg_q[0];
        w_shift = w_bit_end;
      end
      S_PAR:   w_tx = r_parity;
      default: begin
        w_tx    = 1'b1;
        w_load  = 1'b0;
        w_shift = 1'b0;
      end
    endcase
  end

  assign bus.tx         = w_tx;
  assign bus.reg_load   = w_load;
  assign bus.reg_shift  = w_shift;
  assign bus.reg_ser_in = 1'b0;
  assign bus.reg_pdata  = r_pdata;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.bit_idx    = r_bit_cnt;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_tx_ctrl
//   Two controller instances: h[0] with the default parameters, h[1] with
//   BIT_CYCLES=3 and PARITY=0. Each instance gets a behavioural model of the
//   4-bit load/shift register, a frame model that lays out the expected
//   per-cycle outputs of an accepted frame into exp_q, and a monitor that
//   pops one entry for every cycle the DUT reports busy.
// ---------------------------------------------------------------------------
module tb_shift_tx_ctrl;

  localparam int N  = 4;
  localparam int BW = $clog2(N + 1);
  localparam int W  = N + 3 + BW;  // {pdata, tx, load, shift, bit_idx}

  // ---------------- clock / reset ----------------
  logic clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  logic         reset;
  logic         start_s [2];
  logic [N-1:0] data_s  [2];
  bit           mon_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int g,
                       input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, g, $time, got, exp);
    end
  endtask

  // ---------------- per-configuration harness ----------------
  for (genvar g = 0; g < 2; g++) begin : h
    localparam int BC = (g == 0) ? 1 : 3;
    localparam int PB = (g == 0) ? 1 : 0;
    localparam int FL = 1 + BC * (N + PB + 2);

    shift_tx_ctrl_if #(.NBITS(N)) ifc ();
    logic [2:0]   dbg_state;
    logic [N-1:0] reg_q;
    logic [W-1:0] exp_q[$];
    int           model_rem = 0;
    bit           exp_done  = 1'b0;

    assign ifc.start   = start_s[g];
    assign ifc.data_in = data_s[g];
    assign ifc.reg_q   = reg_q;

    shift_tx_ctrl #(.NBITS(N), .BIT_CYCLES(BC), .PARITY(PB)) dut (
      .clk_2       (clk_2),
      .reset       (reset),
      .bus         (ifc),
      .o_dbg_state (dbg_state)
    );

    // Behavioural 4-bit load / shift-right register.
    always_ff @(posedge clk_2) begin
      if (reset)              reg_q <= '0;
      else if (ifc.reg_load)  reg_q <= ifc.reg_pdata;
      else if (ifc.reg_shift) reg_q <= {ifc.reg_ser_in, reg_q[N-1:1]};
    end

    function automatic logic [W-1:0] rec(input logic [N-1:0] d, input logic tx,
                                         input logic ld, input logic sh, input int idx);
      logic [BW-1:0] bi;
      bi = idx[BW-1:0];
      return {d, tx, ld, sh, bi};
    endfunction

    // Expected busy-cycle outputs of one frame carrying word d.
    task automatic push_frame(input logic [N-1:0] d);
      exp_q.push_back(rec(d, 1'b1, 1'b1, 1'b0, 0));
      for (int c = 0; c < BC; c++) exp_q.push_back(rec(d, 1'b0, 1'b0, 1'b0, 0));
      for (int i = 0; i < N; i++)
        for (int c = 0; c < BC; c++)
          exp_q.push_back(rec(d, d[i], 1'b0, (c == BC - 1), i));
      if (PB != 0)
        for (int c = 0; c < BC; c++) exp_q.push_back(rec(d, ^d, 1'b0, 1'b0, N));
      for (int c = 0; c < BC; c++) exp_q.push_back(rec(d, 1'b1, 1'b0, 1'b0, N));
    endtask

    // Frame model: a frame occupies FL cycles after the accepting edge; a new
    // request is taken only once the previous frame has fully elapsed.
    always @(posedge clk_2) begin
      if (reset) begin
        model_rem = 0;
        exp_done  = 1'b0;
        exp_q.delete();
      end else begin
        exp_done = (model_rem == 1);
        if (model_rem > 0) model_rem--;
        else if (start_s[g]) begin
          push_frame(data_s[g]);
          model_rem = FL;
        end
      end
    end

    // Monitor.
    always @(negedge clk_2) begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      if (mon_en) begin
        got = {ifc.reg_pdata, ifc.tx, ifc.reg_load, ifc.reg_shift, ifc.bit_idx};
        check("busy", g, 32'(ifc.busy), 32'(model_rem > 0));
        check("done", g, 32'(ifc.done), 32'(exp_done));
        check("ser_in", g, 32'(ifc.reg_ser_in), 32'(1'b0));
        if (ifc.busy) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_cycle inst%0d t=%0t: got busy cycle %h expected none", g, $time, got);
          end else begin
            exp = exp_q.pop_front();
            check("frame_cycle", g, 32'(got), 32'(exp));
          end
        end else begin
          check("idle_outputs", g, 32'(got[W-N-1:0]), 32'({1'b1, 1'b0, 1'b0, {BW{1'b0}}}));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_2);
      #2;
    end
  endtask

  task automatic send(input int g, input logic [N-1:0] d);
    start_s[g] = 1'b1;
    data_s[g]  = d;
    tick(1);
    start_s[g] = 1'b0;
  endtask

  task automatic rand_drive(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      start_s[g] = ($urandom_range(0, 3) == 0);
      data_s[g]  = N'($urandom);
      tick(1);
    end
    start_s[g] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    reset      = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    data_s[0]  = '0;
    data_s[1]  = '0;
    tick(3);
    reset  = 1'b0;
    mon_en = 1'b1;
    check("reset_pdata", 0, 32'(h[0].ifc.reg_pdata), 32'(0));
    check("reset_pdata", 1, 32'(h[1].ifc.reg_pdata), 32'(0));
    tick(2);

    // Basic frame and zero word.
    send(0, 4'b1011);
    tick(10);
    send(0, 4'b0000);
    tick(10);

    // Held start: back-to-back frames.
    start_s[0] = 1'b1;
    data_s[0]  = 4'b0110;
    tick(27);
    start_s[0] = 1'b0;
    tick(12);

    // Reset during the second data bit.
    send(0, 4'b1011);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(12);

    // Input changes while busy.
    send(0, 4'b1011);
    for (int i = 0; i < 6; i++) begin
      start_s[0] = 1'($urandom_range(0, 1));
      data_s[0]  = 4'b0100;
      tick(1);
    end
    start_s[0] = 1'b0;
    tick(6);

    // Slow configuration without parity.
    send(1, 4'b1001);
    tick(22);

    // Randomised traffic on both instances.
    fork
      rand_drive(0, 200);
      rand_drive(1, 200);
    join

    waited = 0;
    while ((h[0].model_rem > 0 || h[1].model_rem > 0) && waited < 100) begin
      tick(1);
      waited++;
    end
    tick(3);
    check("drain_timeout", 0, 32'(waited < 100), 32'(1));
    check("queue_empty", 0, 32'(h[0].exp_q.size()), 32'(0));
    check("queue_empty", 1, 32'(h[1].exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
